// File: rtl/irq_pending_latch_if.sv
// Request, acknowledge and status signals shared by the interrupt pending latch
// and whatever sources its requests and consumes its pending vector.
interface irq_pending_latch_if;
  logic [3:0] req_in;
  logic [3:0] mask_in;
  logic       ack;
  logic [1:0] ack_code;
  logic       ovf_clr;
  logic [3:0] pend_out;
  logic       any_pend;
  logic [2:0] pend_cnt;
  logic [3:0] ovf;

  modport master (
    output req_in,
    output mask_in,
    output ack,
    output ack_code,
    output ovf_clr,
    input  pend_out,
    input  any_pend,
    input  pend_cnt,
    input  ovf
  );

  modport slave (
    input  req_in,
    input  mask_in,
    input  ack,
    input  ack_code,
    input  ovf_clr,
    output pend_out,
    output any_pend,
    output pend_cnt,
    output ovf
  );
endinterface

// File: rtl/irq_pending_latch.sv
// Synchronises four asynchronous request lines and holds them as pending bits
// for the downstream priority encoder, retiring them on acknowledge.
module irq_pending_latch #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  irq_pending_latch_if.slave bus
);

  // SYNC_STAGES is expected to be 2..4.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_d [SYNC_STAGES];
  logic [3:0] prev_q;
  logic [3:0] prev_d;
  logic [3:0] pend_q;
  logic [3:0] pend_d;
  logic [3:0] ovf_q;
  logic [3:0] ovf_d;
  logic       any_pend_q;
  logic       any_pend_d;
  logic [2:0] pend_cnt_q;
  logic [2:0] pend_cnt_d;

  logic [3:0] sync_s;
  logic [3:0] edge_s;
  logic [3:0] clr_s;

  // Synchroniser chain shift
  always_comb begin
    sync_d[0] = bus.req_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Edge detection and clear decoding
  always_comb begin
    sync_s = sync_q[SYNC_STAGES-1];
    prev_d = sync_s;
    edge_s = sync_s & ~prev_q & ~bus.mask_in;
    if (bus.ack) begin
      clr_s = 4'b0001 << bus.ack_code;
    end else begin
      clr_s = 4'b0000;
    end
  end

  // Pending and overflow next state; a set on the same bit beats a clear
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (EDGE_MODE != 0) begin
      pend_d = edge_s | (pend_q & ~clr_s);
      if (bus.ovf_clr) begin
        ovf_d = (edge_s & pend_q & ~clr_s);
      end else begin
        ovf_d = ovf_q | (edge_s & pend_q & ~clr_s);
      end
    end else begin
      pend_d = (sync_s & ~bus.mask_in) | (pend_q & ~clr_s & ~bus.mask_in);
      ovf_d  = 4'b0000;
    end
  end

  // Status derived from next-state pending so it lines up with pend_out
  always_comb begin
    any_pend_d = |pend_d;
    pend_cnt_d = popcount4(pend_d);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= 4'b0000;
      end
      prev_q     <= 4'b0000;
      pend_q     <= 4'b0000;
      ovf_q      <= 4'b0000;
      any_pend_q <= 1'b0;
      pend_cnt_q <= 3'd0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      prev_q     <= prev_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      any_pend_q <= any_pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign bus.pend_out = pend_q;
  assign bus.any_pend = any_pend_q;
  assign bus.pend_cnt = pend_cnt_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Drives an edge-mode and a level-mode latch with the same stimulus and checks
// both against a sample-history reference model every cycle.
module tb_irq_pending_latch;
  localparam int ES = 2;
  localparam int LS = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] mask;
  logic       ack;
  logic [1:0] ack_code;
  logic       ovf_clr;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: hist[k] is the req vector sampled k edges ago.
  logic [3:0] hist_e [0:4];
  logic [3:0] hist_l [0:4];
  logic [3:0] pend_e, ovf_e, pend_l;

  irq_pending_latch_if if_e ();
  irq_pending_latch_if if_l ();

  assign if_e.req_in = req;   assign if_l.req_in = req;
  assign if_e.mask_in = mask; assign if_l.mask_in = mask;
  assign if_e.ack = ack;      assign if_l.ack = ack;
  assign if_e.ack_code = ack_code; assign if_l.ack_code = ack_code;
  assign if_e.ovf_clr = ovf_clr;   assign if_l.ovf_clr = ovf_clr;

  irq_pending_latch #(.SYNC_STAGES(ES), .EDGE_MODE(1)) dut_e (.clk(clk), .rst_n(rst_n), .bus(if_e));
  irq_pending_latch #(.SYNC_STAGES(LS), .EDGE_MODE(0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] s, p, np, no;
    logic e, c;
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) begin
        hist_e[k] = 4'b0000;
        hist_l[k] = 4'b0000;
      end
      pend_e = 4'b0000; ovf_e = 4'b0000; pend_l = 4'b0000;
    end else begin
      s = hist_e[ES-1]; p = hist_e[ES];
      np = pend_e; no = ovf_e;
      for (int i = 0; i < 4; i++) begin
        e = s[i] && !p[i] && !mask[i];
        c = ack && (int'(ack_code) == i);
        if (ovf_clr) no[i] = 1'b0;
        if (e && pend_e[i] && !c) no[i] = 1'b1;
        if (e) np[i] = 1'b1;
        else if (c) np[i] = 1'b0;
      end
      pend_e = np; ovf_e = no;
      s = hist_l[LS-1];
      np = pend_l;
      for (int i = 0; i < 4; i++) begin
        c = ack && (int'(ack_code) == i);
        if (mask[i]) np[i] = 1'b0;
        else if (s[i]) np[i] = 1'b1;
        else if (c) np[i] = 1'b0;
      end
      pend_l = np;
      for (int k = 4; k > 0; k--) begin
        hist_e[k] = hist_e[k-1];
        hist_l[k] = hist_l[k-1];
      end
      hist_e[0] = req;
      hist_l[0] = req;
    end
  endtask

  task automatic step(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      model_step();
      #1;
      check_eq("e_pend", 32'(if_e.pend_out), 32'(pend_e));
      check_eq("e_any",  32'(if_e.any_pend), 32'(|pend_e));
      check_eq("e_cnt",  32'(if_e.pend_cnt), 32'($countones(pend_e)));
      check_eq("e_ovf",  32'(if_e.ovf), 32'(ovf_e));
      check_eq("l_pend", 32'(if_l.pend_out), 32'(pend_l));
      check_eq("l_any",  32'(if_l.any_pend), 32'(|pend_l));
      check_eq("l_cnt",  32'(if_l.pend_cnt), 32'($countones(pend_l)));
      check_eq("l_ovf",  32'(if_l.ovf), 32'h0);
    end
  endtask

  task automatic do_ack(input logic [1:0] code);
    ack = 1'b1; ack_code = code;
    step(1);
    ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; mask = 4'b0000;
    ack = 1'b0; ack_code = 2'd0; ovf_clr = 1'b0;
    step(2);
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step(1);
      check_eq("rel_pend", 32'(if_e.pend_out), 32'h0);
      check_eq("rel_cnt", 32'(if_e.pend_cnt), 32'h0);
      check_eq("rel_ovf", 32'(if_e.ovf), 32'h0);
    end

    // Request held through reset is captured as an edge after release
    req = 4'b0100; rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    check_eq("hold_early", 32'(if_e.pend_out), 32'h0);
    step(1);
    check_eq("hold_pend", 32'(if_e.pend_out), 32'h4);
    req = 4'b0000;
    step(4);
    do_ack(2'd2);
    step(2);

    // Two simultaneous requests, real ack, then a stale ack
    req = 4'b1010;
    step(2);
    req = 4'b0000;
    step(1);
    check_eq("multi_pend", 32'(if_e.pend_out), 32'ha);
    check_eq("multi_cnt", 32'(if_e.pend_cnt), 32'h2);
    do_ack(2'd3);
    check_eq("ack3_pend", 32'(if_e.pend_out), 32'h2);
    check_eq("ack3_cnt", 32'(if_e.pend_cnt), 32'h1);
    do_ack(2'd0);
    check_eq("stale_pend", 32'(if_e.pend_out), 32'h2);
    step(2);

    // Second edge on pending bit 1 overflows; then clear; then edge + ack
    req = 4'b0010;
    step(2);
    req = 4'b0000;
    step(1);
    check_eq("ovf_set", 32'(if_e.ovf), 32'h2);
    check_eq("ovf_pend", 32'(if_e.pend_out), 32'h2);
    step(2);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check_eq("ovf_clr", 32'(if_e.ovf), 32'h0);
    step(2);
    req = 4'b0010;
    step(2);
    req = 4'b0000;
    do_ack(2'd1);
    check_eq("setclr_pend", 32'(if_e.pend_out), 32'h2);
    check_eq("setclr_ovf", 32'(if_e.ovf), 32'h0);
    do_ack(2'd1);
    step(2);

    // Masked edge is discarded; unmasking a held line is not a new edge
    mask = 4'b0001; req = 4'b0001;
    step(4);
    check_eq("mask_pend", 32'(if_e.pend_out), 32'h0);
    mask = 4'b0000;
    step(4);
    check_eq("unmask_pend", 32'(if_e.pend_out), 32'h0);
    req = 4'b0000;
    step(4);

    // Level mode re-asserts while the line is held, clears once dropped
    req = 4'b1000;
    step(4);
    check_eq("lvl_set", 32'(if_l.pend_out[3]), 32'h1);
    do_ack(2'd3);
    check_eq("lvl_hold", 32'(if_l.pend_out[3]), 32'h1);
    step(1);
    check_eq("lvl_back", 32'(if_l.pend_out[3]), 32'h1);
    req = 4'b0000;
    step(4);
    do_ack(2'd3);
    check_eq("lvl_clr", 32'(if_l.pend_out[3]), 32'h0);
    step(2);
    check_eq("lvl_stay", 32'(if_l.pend_out[3]), 32'h0);

    // Reset in the middle of pending and overflow state
    req = 4'b1111;
    step(4);
    check_eq("all_pend", 32'(if_e.pend_out), 32'hf);
    req = 4'b1011;
    step(3);
    req = 4'b1111;
    step(3);
    check_eq("mid_ovf", 32'(if_e.ovf), 32'h4);
    req = 4'b0000; rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check_eq("mid_pend", 32'(if_e.pend_out), 32'h0);
    check_eq("mid_any", 32'(if_e.any_pend), 32'h0);
    check_eq("mid_cnt", 32'(if_e.pend_cnt), 32'h0);
    check_eq("mid_ovf0", 32'(if_e.ovf), 32'h0);
    step(1);
    check_eq("post_pend", 32'(if_e.pend_out), 32'h0);
    step(3);

    // Randomised traffic
    for (int j = 0; j < 2000; j++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom) & 4'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      ack_code = 2'($urandom);
      ovf_clr = ($urandom_range(0, 19) == 0);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/irq_pending_latch.md
# irq_pending_latch

Upstream capture stage for the 4-input priority encoder. It synchronises four asynchronous request lines, detects their rising edges and holds each request as a sticky pending bit. The registered pending vector drives the encoder's inputs. The encoder's 2-bit code is fed back with an acknowledge strobe to retire the serviced request. Overflow flags and a pending count are provided for status and debug.

## Interface
- SYNC_STAGES, default 2: synchroniser depth per request line; legal range 2–4.
- EDGE_MODE, default 1: 1 = rising-edge capture (sticky); 0 = level mode (pending follows the synchronised level).

- clk, input, 1: single clock; all flops are rising-edge.
- rst_n, input, 1: reset; synchronous, active-low.
- req_in, input, 4: asynchronous request lines; bit 3 is highest priority, bit 0 lowest.
- mask_in, input, 4: synchronous; 1 = ignore that line. Masked edges are discarded, not deferred.
- ack, input, 1: one-cycle strobe meaning the encoder's current code has been serviced.
- ack_code, input, 2: index of the bit to retire; code n clears pend_out[n].
- ovf_clr, input, 1: clears all overflow flags.
- pend_out, output, 4: registered pending vector; feeds the encoder inputs.
- any_pend, output, 1: registered OR of pend_out.
- pend_cnt, output, 3: registered population count of pend_out, range 0–4.
- ovf, output, 4: sticky per-line flag; set when an edge arrives on a line already pending.

## Operation
- **Synchroniser.** Per line, a chain of SYNC_STAGES flops. The last stage is `sync[i]`. A further flop `prev[i]` holds the previous `sync[i]`.
- **Edge detect.** `edge[i] = sync[i] & ~prev[i] & ~mask_in[i]`.
- **Clear term.** `clr[i] = ack & (ack_code == i)`.
- **Pending update, EDGE_MODE=1.** `pend[i] <= edge[i] | (pend[i] & ~clr[i])`.
  - Set wins over clear on the same bit in the same cycle.
- **Pending update, EDGE_MODE=0.** `pend[i] <= (sync[i] & ~mask_in[i]) | (pend[i] & ~clr[i] & ~mask_in[i])`.
  - A line still held high re-asserts pending on the cycle after the ack.
- **Stale ack.** An ack whose ack_code selects a non-pending bit causes no state change.
- **Overflow.** `ovf[i]` is set when `edge[i] & pend[i] & ~clr[i]`, i.e. the old request is lost.
  - The simultaneous edge+clear case is not an overflow.
  - ovf_clr zeroes all ovf bits. If a set and ovf_clr occur in the same cycle, the set wins.
  - ovf is unused in EDGE_MODE=0 and stays 0.
- **Mask changes.** Mask changes take effect on the next clock edge. Masking a line does not clear an existing pending bit in EDGE_MODE=1; it does in EDGE_MODE=0.
- **Status outputs.** any_pend and pend_cnt are computed from the next-state pending value and registered, so they are always coherent with pend_out in the same cycle.

## Timing
- **Reset.** While rst_n=0 at a clock edge, every flop goes to 0: synchroniser chains, prev, pend_out, any_pend, pend_cnt and ovf.
  - A request held high through reset is therefore seen as a rising edge after release.
  - It becomes pending SYNC_STAGES+1 cycles after the first post-reset edge.
- **Request latency.** Let req_in rise before edge k. Then sync is high after edge k+SYNC_STAGES-1, and pend_out is high after edge k+SYNC_STAGES. This is 3 cycles with the default depth.
- **Ack latency.** ack sampled at edge j clears the bit after edge j; any_pend and pend_cnt update at the same edge.
- **Minimum pulse width.** Pulses shorter than one clock period may be missed; this is not a defect.
- **Back-to-back acks.** Acks on consecutive cycles with different codes are legal. Each retires one bit.
- **Reset mid-operation.** Reset mid-operation discards all pending and overflow state with no partial clears. The first cycle after release shows all outputs 0.

## Test plan
- **Reset and release.** Reset, then release with req_in=0000 → pend_out=0000, any_pend=0, pend_cnt=0 and ovf=0000 for 10 cycles. Next, hold req_in[2]=1 through reset → pend_out=0100 exactly 3 cycles after release.
- **Multiple requests and acks.** Pulse req_in=1010 for 2 cycles → pend_out=1010 and pend_cnt=2 after 3 cycles. Ack with code 3 → pend_out=0010 and pend_cnt=1 next cycle. Ack with code 0 (stale) → no change.
- **Edge on a pending line.** Pend bit 1. A second edge on req_in[1] without an ack → ovf=0010 and pend_out unchanged. Then ovf_clr → ovf=0000. Finally, an edge coinciding with ack code 1 → pend_out[1] stays 1 and ovf stays 0000.
- **Mask.** Set mask_in=0001 and pulse req_in[0] → pend_out[0] never sets. Unmask with req_in[0] still high → no capture (no new edge).
- **Level mode (EDGE_MODE=0).** Hold req_in[3]=1 and ack code 3 → pend_out[3] returns to 1 one cycle later. Drop req_in[3] then ack → bit clears and stays clear.
- **Reset mid-operation.** Pend 1111 and ovf=0100, then assert rst_n=0 for 1 cycle → all outputs 0 on the next edge, with no residual pending.
